// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, constants and helpers
//
// Purpose: definitions shared by uart_rx and uart_tx.
//   uart_state_e : 3-bit FSM state encoding (IDLE, START, DATA, PARITY, STOP, CLEANUP)
//   UART_DATA_W  : data bits per frame
//   UART_MIN_CPB : smallest usable clocks-per-bit value
//   clamp_cpb()  : raises a run-time clocks-per-bit value to UART_MIN_CPB

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_CLEANUP = 3'd5
  } uart_state_e;

  localparam int unsigned UART_DATA_W  = 8;
  localparam logic [15:0] UART_MIN_CPB = 16'd2;

  // A bit time of 0 or 1 clock cannot be counted by a 0..N-1 counter
  // that needs a distinct last cycle, so small values are raised.
  function automatic logic [15:0] clamp_cpb(input logic [15:0] cpb);
    return (cpb < UART_MIN_CPB) ? UART_MIN_CPB : cpb;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous FIFO with registered full/empty flags
//
// Purpose: byte queue between the register block and the UART transmitter.
// Parameters:
//   DEPTH  : number of entries, power of two, at least 2
//   WIDTH  : entry width in bits
// Ports:
//   clk_i       : clock
//   rst_ni      : asynchronous active-low reset, empties the FIFO
//   push_i      : write strobe, ignored while full (even with a same-cycle pop)
//   push_data_i : data written on an accepted push
//   pop_i       : read strobe, ignored while empty
//   pop_data_o  : current head entry (valid while not empty)
//   full_o      : registered, FIFO holds DEPTH entries
//   empty_o     : registered, FIFO holds no entries

module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  // Acceptance uses the registered flags only, so a push into a full FIFO
  // is dropped even when a pop frees an entry in the same cycle.
  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  always_comb begin
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, 8N1 (or 8E1) with a byte FIFO
//
// Purpose: queues bytes and serialises them LSB first as start, 8 data,
// optional even parity and stop bit. Bit time is CLKS_PER_BIT clocks,
// latched per frame and raised to at least 2.
// Build option: define UART_TX_PARITY_EN for 8E1 frames (adds the PARITY state).
// Parameters:
//   FIFO_DEPTH   : TX FIFO entries, power of two, at least 2
// Ports:
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset, abandons any frame and flushes the FIFO
//   tx_en        : allows new frames to start; a frame in flight always completes
//   i_Tx_DV      : write strobe for i_Tx_Byte
//   i_Tx_Byte    : byte to queue
//   CLKS_PER_BIT : clocks per bit
//   o_Tx_Serial  : registered serial line, idles high
//   o_Tx_Active  : high from the first start-bit cycle through the last stop-bit cycle
//   o_Tx_Done    : one-cycle pulse on the last stop-bit cycle
//   o_Tx_Full    : FIFO full
//   o_Tx_Empty   : FIFO empty

module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tx_en,
  input  logic        i_Tx_DV,
  input  logic [7:0]  i_Tx_Byte,
  input  logic [15:0] CLKS_PER_BIT,
  output logic        o_Tx_Serial,
  output logic        o_Tx_Active,
  output logic        o_Tx_Done,
  output logic        o_Tx_Full,
  output logic        o_Tx_Empty
);

  uart_state_e            state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [15:0]            cpb_q, cpb_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   serial_q, serial_d;
  logic                   active_q, active_d;
  logic                   done_q, done_d;

  logic                   fifo_pop;
  logic                   fifo_full, fifo_empty;
  logic [UART_DATA_W-1:0] fifo_head;
  logic                   bit_end;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (i_Tx_DV),
    .push_data_i (i_Tx_Byte),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Last cycle of the current bit time.
  assign bit_end = (cnt_q == (cpb_q - 16'd1));

  // Line, active and done are computed from the current state and registered,
  // so they trail the state register by one cycle. Every state therefore maps
  // onto exactly its own span of cycles on the pad, and the pad is glitch-free.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cpb_d     = cpb_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = 1'b1;
    active_d  = 1'b0;
    done_d    = 1'b0;
    fifo_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (tx_en && !fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          cpb_d    = clamp_cpb(CLKS_PER_BIT);
          state_d  = ST_START;
        end
      end

      ST_START: begin
        serial_d = 1'b0;
        active_d = 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_DATA: begin
        serial_d = shift_q[bit_idx_q];
        active_d = 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        // Even parity: the parity bit makes the count of ones even.
        serial_d = ^shift_q;
        active_d = 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif

      ST_STOP: begin
        serial_d = 1'b1;
        active_d = 1'b1;
        if (bit_end) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_CLEANUP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_CLEANUP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cpb_q     <= UART_MIN_CPB;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cpb_q     <= cpb_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;
  assign o_Tx_Full   = fifo_full;
  assign o_Tx_Empty  = fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level model

module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int MAXS = 256;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        tx_en;
  logic        i_Tx_DV;
  logic [7:0]  i_Tx_Byte;
  logic [15:0] CLKS_PER_BIT;
  logic        o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Full, o_Tx_Empty;

  int checks = 0;
  int errors = 0;

  logic ser_s  [MAXS];
  logic act_s  [MAXS];
  logic done_s [MAXS];

  uart_tx #(.FIFO_DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .tx_en        (tx_en),
    .i_Tx_DV      (i_Tx_DV),
    .i_Tx_Byte    (i_Tx_Byte),
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .o_Tx_Serial  (o_Tx_Serial),
    .o_Tx_Active  (o_Tx_Active),
    .o_Tx_Done    (o_Tx_Done),
    .o_Tx_Full    (o_Tx_Full),
    .o_Tx_Empty   (o_Tx_Empty)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  // Model: line level k cycles after the first start-bit cycle.
  function automatic logic exp_line(input logic [7:0] b, input int cpb, input int k);
    int idx;
    idx = k / cpb;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic int eff_cpb(input int cpb);
    return (cpb < 2) ? 2 : cpb;
  endfunction

  // First recorded cycle that departs from an ideal frame, or -1.
  function automatic int frame_mismatch(input logic [7:0] b, input int cpb, input int n);
    int len;
    len = FRAME_BITS * cpb;
    for (int k = 0; k < n; k++)
      if (ser_s[k] !== exp_line(b, cpb, k) || act_s[k] !== (k < len) || done_s[k] !== (k == len - 1))
        return k;
    return -1;
  endfunction

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    i_Tx_DV   = 1'b1;
    i_Tx_Byte = b;
    @(negedge clk);
    i_Tx_DV   = 1'b0;
  endtask

  task automatic wait_start(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (o_Tx_Serial === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic record(input int from, input int to);
    for (int k = from; k < to; k++) begin
      ser_s[k]  = o_Tx_Serial;
      act_s[k]  = o_Tx_Active;
      done_s[k] = o_Tx_Done;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; tx_en = 1'b0; i_Tx_DV = 1'b0; i_Tx_Byte = 8'h00; CLKS_PER_BIT = 16'd4;
    repeat (3) @(negedge clk);
    checks++; if (o_Tx_Serial !== 1'b1) begin errors++; $display("FAIL reset_serial got %b want 1", o_Tx_Serial); end
    checks++; if (o_Tx_Active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", o_Tx_Active); end
    checks++; if (o_Tx_Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_Tx_Done); end
    checks++; if (o_Tx_Full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", o_Tx_Full); end
    checks++; if (o_Tx_Empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", o_Tx_Empty); end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int len, m;
    CLKS_PER_BIT = 16'd4;
    tx_en = 1'b1;
    len = FRAME_BITS * 4;
    push(8'h55);
    checks++; if (o_Tx_Empty !== 1'b0 || o_Tx_Serial !== 1'b1)
      begin errors++; $display("FAIL latency_push empty/serial got %b/%b want 0/1", o_Tx_Empty, o_Tx_Serial); end
    @(negedge clk);
    checks++; if (o_Tx_Empty !== 1'b1 || o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0)
      begin errors++; $display("FAIL latency_pop empty/serial/active got %b/%b/%b want 1/1/0", o_Tx_Empty, o_Tx_Serial, o_Tx_Active); end
    @(negedge clk);
    checks++; if (o_Tx_Serial !== 1'b0 || o_Tx_Active !== 1'b1)
      begin errors++; $display("FAIL latency_start serial/active got %b/%b want 0/1", o_Tx_Serial, o_Tx_Active); end
    record(0, len + 2);
    m = frame_mismatch(8'h55, 4, len + 2);
    checks++; if (m >= 0) begin errors++; $display("FAIL basic_frame 0x55 at cycle %0d line/act/done got %b%b%b want %b%b%b",
      m, ser_s[m], act_s[m], done_s[m], exp_line(8'h55, 4, m), m < len, m == len - 1); end
  endtask

  task automatic test_parity_bytes;
    logic [7:0] bytes [2];
    logic       want_par [2];
    bit ok;
    int len, m;
    bytes[0] = 8'h07; want_par[0] = 1'b1;
    bytes[1] = 8'h03; want_par[1] = 1'b0;
    CLKS_PER_BIT = 16'd4;
    tx_en = 1'b1;
    len = FRAME_BITS * 4;
    for (int i = 0; i < 2; i++) begin
      push(bytes[i]);
      wait_start(20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL parity_start byte 0x%02h got no start want start", bytes[i]); end
      record(0, len + 2);
      m = frame_mismatch(bytes[i], 4, len + 2);
      checks++; if (m >= 0) begin errors++; $display("FAIL parity_frame 0x%02h at cycle %0d line got %b want %b",
        bytes[i], m, ser_s[m], exp_line(bytes[i], 4, m)); end
`ifdef UART_TX_PARITY_EN
      checks++; if (ser_s[37] !== want_par[i]) begin errors++; $display("FAIL parity_bit 0x%02h got %b want %b",
        bytes[i], ser_s[37], want_par[i]); end
`else
      checks++; if (ser_s[37] !== 1'b1) begin errors++; $display("FAIL stop_after_data 0x%02h got %b want 1 (parity %b unused)",
        bytes[i], ser_s[37], want_par[i]); end
`endif
    end
  endtask

  task automatic test_random;
    logic [7:0] b;
    int cpb, e, len, m;
    bit ok;
    tx_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b   = 8'($urandom);
      cpb = (i < 2) ? i : int'($urandom_range(2, 7));
      e   = eff_cpb(cpb);
      len = FRAME_BITS * e;
      CLKS_PER_BIT = 16'(cpb);
      push(b);
      wait_start(20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_start byte 0x%02h cpb %0d got no start want start", b, cpb); end
      record(0, len + 2);
      m = frame_mismatch(b, e, len + 2);
      checks++; if (m >= 0) begin errors++; $display("FAIL rand_frame 0x%02h cpb %0d at cycle %0d line/act/done got %b%b%b want %b%b%b",
        b, cpb, m, ser_s[m], act_s[m], done_s[m], exp_line(b, e, m), m < e * FRAME_BITS, m == e * FRAME_BITS - 1); end
    end
  endtask

  task automatic test_cpb_change;
    logic [7:0] a, b;
    bit ok;
    int m;
    a = 8'($urandom); b = 8'($urandom);
    tx_en = 1'b0;
    CLKS_PER_BIT = 16'd4;
    push(a);
    push(b);
    @(negedge clk);
    tx_en = 1'b1;
    wait_start(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cpb_start got no start want start"); end
    record(0, 6);
    CLKS_PER_BIT = 16'd8;
    record(6, FRAME_BITS * 4 + 2);
    m = frame_mismatch(a, 4, FRAME_BITS * 4 + 2);
    checks++; if (m >= 0) begin errors++; $display("FAIL cpb_hold 0x%02h at cycle %0d line got %b want %b", a, m, ser_s[m], exp_line(a, 4, m)); end
    checks++; if (o_Tx_Serial !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b want 0 after 2 idle cycles", o_Tx_Serial); end
    record(0, FRAME_BITS * 8 + 2);
    m = frame_mismatch(b, 8, FRAME_BITS * 8 + 2);
    checks++; if (m >= 0) begin errors++; $display("FAIL cpb_next 0x%02h at cycle %0d line got %b want %b", b, m, ser_s[m], exp_line(b, 8, m)); end
  endtask

  task automatic test_full;
    int len, m, lows;
    bit ok;
    tx_en = 1'b0;
    CLKS_PER_BIT = 16'd3;
    len = FRAME_BITS * 3;
    for (int i = 1; i <= 3; i++) push(8'(i));
    checks++; if (o_Tx_Full !== 1'b0) begin errors++; $display("FAIL full_after3 got %b want 0", o_Tx_Full); end
    push(8'h04);
    checks++; if (o_Tx_Full !== 1'b1) begin errors++; $display("FAIL full_after4 got %b want 1", o_Tx_Full); end
    push(8'h05);
    checks++; if (o_Tx_Full !== 1'b1 || o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0)
      begin errors++; $display("FAIL full_hold full/serial/active got %b/%b/%b want 1/1/0", o_Tx_Full, o_Tx_Serial, o_Tx_Active); end
    // Enable and push on the same edge: the pop frees a slot but the push must still drop.
    @(negedge clk);
    tx_en = 1'b1; i_Tx_DV = 1'b1; i_Tx_Byte = 8'h66;
    @(negedge clk);
    i_Tx_DV = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 1) begin
        wait_start(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_start got no start want start"); end
      end else begin
        checks++; if (o_Tx_Serial !== 1'b0) begin errors++; $display("FAIL full_gap frame %0d got %b want 0", i, o_Tx_Serial); end
      end
      record(0, len + 2);
      m = frame_mismatch(8'(i), 3, len + 2);
      checks++; if (m >= 0) begin errors++; $display("FAIL full_frame 0x%02h at cycle %0d line got %b want %b",
        i, m, ser_s[m], exp_line(8'(i), 3, m)); end
    end
    lows = 0;
    for (int k = 0; k < 100; k++) begin
      if (o_Tx_Serial !== 1'b1) lows++;
      @(negedge clk);
    end
    checks++; if (lows != 0 || o_Tx_Empty !== 1'b1) begin errors++; $display("FAIL full_drop low_cycles/empty got %0d/%b want 0/1", lows, o_Tx_Empty); end
  endtask

  task automatic test_reset_mid;
    int lows;
    bit ok;
    tx_en = 1'b0;
    CLKS_PER_BIT = 16'd4;
    push(8'hA5); push(8'h3C); push(8'hF0);
    @(negedge clk);
    tx_en = 1'b1;
    wait_start(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_start got no start want start"); end
    record(0, 17);
    rst_ni = 1'b0;
    #1;
    checks++; if (o_Tx_Serial !== 1'b1 || o_Tx_Empty !== 1'b1 || o_Tx_Active !== 1'b0)
      begin errors++; $display("FAIL rmid_async serial/empty/active got %b/%b/%b want 1/1/0", o_Tx_Serial, o_Tx_Empty, o_Tx_Active); end
    @(negedge clk);
    rst_ni = 1'b1;
    lows = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL rmid_no_resume active_cycles got %0d want 0", lows); end
  endtask

  task automatic test_tx_en_low;
    logic [7:0] a, b;
    int len, m, lows;
    bit ok;
    a = 8'($urandom); b = 8'($urandom);
    tx_en = 1'b0;
    CLKS_PER_BIT = 16'd4;
    len = FRAME_BITS * 4;
    push(a); push(b);
    @(negedge clk);
    tx_en = 1'b1;
    wait_start(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL txen_start got no start want start"); end
    record(0, 14);
    tx_en = 1'b0;
    record(14, len + 2);
    m = frame_mismatch(a, 4, len + 2);
    checks++; if (m >= 0) begin errors++; $display("FAIL txen_complete 0x%02h at cycle %0d line/act/done got %b%b%b want %b%b%b",
      a, m, ser_s[m], act_s[m], done_s[m], exp_line(a, 4, m), m < len, m == len - 1); end
    lows = 0;
    for (int k = 0; k < 3 * len; k++) begin
      if (o_Tx_Serial !== 1'b1) lows++;
      @(negedge clk);
    end
    checks++; if (lows != 0 || o_Tx_Empty !== 1'b0) begin errors++; $display("FAIL txen_hold low_cycles/empty got %0d/%b want 0/0", lows, o_Tx_Empty); end
    tx_en = 1'b1;
    wait_start(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL txen_resume got no start want start"); end
    record(0, len + 2);
    m = frame_mismatch(b, 4, len + 2);
    checks++; if (m >= 0) begin errors++; $display("FAIL txen_second 0x%02h at cycle %0d line got %b want %b", b, m, ser_s[m], exp_line(b, 4, m)); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity_bytes;
    test_random;
    test_cpb_change;
    test_full;
    test_reset_mid;
    test_tx_en_low;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
